// File: rtl/raster_pkg.sv
// Shared types for the line rasterizer: FSM states, coordinate, delta and error types.
package raster_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned DELTA_W = 12;
    localparam int unsigned ERR_W   = 13;
    localparam int unsigned PIXX_W  = 10;
    localparam int unsigned PIXY_W  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SETUP = 2'd2,
        DRAW  = 2'd3
    } state_e;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic        [COLOR_W-1:0] color_t;
    typedef logic signed [DELTA_W-1:0] delta_t;
    typedef logic signed [ERR_W-1:0]   err_t;

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: next point and error term from the current ones.
module bresenham_step
    import raster_pkg::*;
(
    input  coord_t i_cx,
    input  coord_t i_cy,
    input  err_t   i_err,
    input  delta_t i_dx,
    input  delta_t i_dy,
    input  logic   i_sx_neg,
    input  logic   i_sy_neg,
    output coord_t o_cx,
    output coord_t o_cy,
    output err_t   o_err
);

    logic signed [ERR_W:0] w_e2;
    logic signed [ERR_W:0] w_dx_ext;
    logic signed [ERR_W:0] w_dy_ext;

    assign w_e2     = {i_err, 1'b0};
    assign w_dx_ext = (ERR_W+1)'(i_dx);
    assign w_dy_ext = (ERR_W+1)'(i_dy);

    // Both tests use the pre-update error, so the two updates accumulate independently.
    always_comb begin
        o_cx  = i_cx;
        o_cy  = i_cy;
        o_err = i_err;
        if (w_e2 >= w_dy_ext) begin
            o_err = o_err + err_t'(i_dy);
            o_cx  = i_sx_neg ? (i_cx - coord_t'(1)) : (i_cx + coord_t'(1));
        end
        if (w_e2 <= w_dx_ext) begin
            o_err = o_err + err_t'(i_dx);
            o_cy  = i_sy_neg ? (i_cy - coord_t'(1)) : (i_cy + coord_t'(1));
        end
    end

endmodule

// File: rtl/line_rasterizer.sv
// Pops line segments from the vector queue and walks them with Bresenham stepping,
// offering each on-screen pixel to the framebuffer over a valid/ready handshake.
module line_rasterizer
    import raster_pkg::*;
#(
    parameter int unsigned WIDTH    = 640,
    parameter int unsigned HEIGHT   = 480,
    parameter int unsigned X_OFFSET = 320,
    parameter int unsigned Y_OFFSET = 240
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [COORD_W-1:0]   qStartX,
    input  logic [COORD_W-1:0]   qStartY,
    input  logic [COORD_W-1:0]   qEndX,
    input  logic [COORD_W-1:0]   qEndY,
    input  logic [COLOR_W-1:0]   qColor,
    input  logic                 qEmpty,
    output logic                 qRead,
    output logic [PIXX_W-1:0]    pixX,
    output logic [PIXY_W-1:0]    pixY,
    output logic [COLOR_W-1:0]   pixColor,
    output logic                 pixValid,
    input  logic                 pixReady,
    output logic                 busy
);

    localparam delta_t LP_W     = delta_t'(WIDTH);
    localparam delta_t LP_H     = delta_t'(HEIGHT);
    localparam delta_t LP_X_OFF = delta_t'(X_OFFSET);
    localparam delta_t LP_Y_OFF = delta_t'(Y_OFFSET);

    state_e              r_state;
    logic                r_qread;
    logic [PIXX_W-1:0]   r_pix_x;
    logic [PIXY_W-1:0]   r_pix_y;
    color_t              r_pix_color;
    logic                r_pix_valid;
    logic                r_busy;
    coord_t              r_cx;
    coord_t              r_cy;
    coord_t              r_x1;
    coord_t              r_y1;
    err_t                r_err;
    delta_t              r_dx;
    delta_t              r_dy;
    logic                r_sx_neg;
    logic                r_sy_neg;

    delta_t              w_dx_raw;
    delta_t              w_dy_raw;
    delta_t              w_dx_abs;
    delta_t              w_dy_nabs;
    coord_t              w_nx;
    coord_t              w_ny;
    err_t                w_nerr;
    coord_t              w_pt_x;
    coord_t              w_pt_y;
    delta_t              w_sxp;
    delta_t              w_syp;
    logic                w_on_screen;
    logic                w_at_end;
    logic                w_advance;

    // Segment deltas, evaluated in SETUP while (r_cx, r_cy) still holds the start point.
    assign w_dx_raw  = delta_t'(r_x1) - delta_t'(r_cx);
    assign w_dy_raw  = delta_t'(r_y1) - delta_t'(r_cy);
    assign w_dx_abs  = w_dx_raw[DELTA_W-1] ? -w_dx_raw : w_dx_raw;
    assign w_dy_nabs = w_dy_raw[DELTA_W-1] ? w_dy_raw : -w_dy_raw;

    bresenham_step u_step (
        .i_cx     (r_cx),
        .i_cy     (r_cy),
        .i_err    (r_err),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .i_sx_neg (r_sx_neg),
        .i_sy_neg (r_sy_neg),
        .o_cx     (w_nx),
        .o_cy     (w_ny),
        .o_err    (w_nerr)
    );

    // Point whose pixel is registered this edge: start point in SETUP, next point in DRAW.
    assign w_pt_x      = (r_state == DRAW) ? w_nx : r_cx;
    assign w_pt_y      = (r_state == DRAW) ? w_ny : r_cy;
    assign w_sxp       = delta_t'(w_pt_x) + LP_X_OFF;
    assign w_syp       = LP_Y_OFF - delta_t'(w_pt_y);
    assign w_on_screen = !w_sxp[DELTA_W-1] && (w_sxp < LP_W) &&
                         !w_syp[DELTA_W-1] && (w_syp < LP_H);

    assign w_at_end  = (r_cx == r_x1) && (r_cy == r_y1);
    assign w_advance = !r_pix_valid || pixReady;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_qread     <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_color <= '0;
            r_pix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_err       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_sx_neg    <= 1'b0;
            r_sy_neg    <= 1'b0;
        end else begin
            r_qread <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!qEmpty) begin
                        r_state <= LOAD;
                        r_qread <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_cx        <= coord_t'(qStartX);
                    r_cy        <= coord_t'(qStartY);
                    r_x1        <= coord_t'(qEndX);
                    r_y1        <= coord_t'(qEndY);
                    r_pix_color <= color_t'(qColor);
                    r_state     <= SETUP;
                end
                SETUP: begin
                    r_dx        <= w_dx_abs;
                    r_dy        <= w_dy_nabs;
                    r_sx_neg    <= !(r_cx < r_x1);
                    r_sy_neg    <= !(r_cy < r_y1);
                    r_err       <= err_t'(w_dx_abs) + err_t'(w_dy_nabs);
                    r_pix_valid <= w_on_screen;
                    r_pix_x     <= w_sxp[PIXX_W-1:0];
                    r_pix_y     <= w_syp[PIXY_W-1:0];
                    r_state     <= DRAW;
                end
                DRAW: begin
                    if (w_advance) begin
                        if (w_at_end) begin
                            r_pix_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_cx        <= w_nx;
                            r_cy        <= w_ny;
                            r_err       <= w_nerr;
                            r_pix_valid <= w_on_screen;
                            r_pix_x     <= w_sxp[PIXX_W-1:0];
                            r_pix_y     <= w_syp[PIXY_W-1:0];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign qRead    = r_qread;
    assign pixX     = r_pix_x;
    assign pixY     = r_pix_y;
    assign pixColor = r_pix_color;
    assign pixValid = r_pix_valid;
    assign busy     = r_busy;

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: software queue + Bresenham reference model.
module tb_line_rasterizer;

    localparam int XO = 320;
    localparam int YO = 240;
    localparam int SW = 640;
    localparam int SH = 480;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [10:0] qStartX = '0, qStartY = '0, qEndX = '0, qEndY = '0;
    logic [2:0]  qColor = '0;
    logic        qEmpty = 1'b1;
    logic        qRead;
    logic [9:0]  pixX;
    logic [8:0]  pixY;
    logic [2:0]  pixColor;
    logic        pixValid;
    logic        pixReady = 1'b1;
    logic        busy;

    always #5 clk = ~clk;

    line_rasterizer dut (
        .clk(clk), .rst_b(rst_b),
        .qStartX(qStartX), .qStartY(qStartY), .qEndX(qEndX), .qEndY(qEndY),
        .qColor(qColor), .qEmpty(qEmpty), .qRead(qRead),
        .pixX(pixX), .pixY(pixY), .pixColor(pixColor),
        .pixValid(pixValid), .pixReady(pixReady), .busy(busy)
    );

    typedef struct { int x0; int y0; int x1; int y1; int c; } seg_t;
    typedef struct { int x; int y; int c; bit on; } pix_t;

    seg_t seg_q[$];
    pix_t exp_q[$];
    pix_t mdl[$];
    pix_t acc_log[$];
    int   valid_cyc[$];
    int   qread_cyc[$];
    int   cyc = 0;
    int   busy_cnt = 0;
    int   last_busy = -1;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   pop_due = 0;
    int   ready_mode = 0;
    bit   stalled = 0;
    int   st_pack = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int pk(input int x, input int y, input int c);
        return (x << 12) | (y << 3) | c;
    endfunction

    // Reference: plain integer Bresenham walk, mapped to screen space with clipping flag.
    task automatic run_model(input seg_t s);
        int x, y, dx, dy, sx, sy, err, e2;
        pix_t p;
        mdl.delete();
        x = s.x0; y = s.y0;
        dx = (s.x1 > s.x0) ? s.x1 - s.x0 : s.x0 - s.x1;
        dy = -((s.y1 > s.y0) ? s.y1 - s.y0 : s.y0 - s.y1);
        sx = (s.x0 < s.x1) ? 1 : -1;
        sy = (s.y0 < s.y1) ? 1 : -1;
        err = dx + dy;
        for (int guard = 0; guard < 5000; guard++) begin
            p.x = x + XO; p.y = YO - y; p.c = s.c;
            p.on = (p.x >= 0) && (p.x < SW) && (p.y >= 0) && (p.y < SH);
            mdl.push_back(p);
            if (x == s.x1 && y == s.y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic drive_head();
        if (seg_q.size() == 0) begin
            qEmpty = 1'b1;
        end else begin
            qEmpty  = 1'b0;
            qStartX = 11'(seg_q[0].x0);
            qStartY = 11'(seg_q[0].y0);
            qEndX   = 11'(seg_q[0].x1);
            qEndY   = 11'(seg_q[0].y1);
            qColor  = 3'(seg_q[0].c);
        end
    endtask

    task automatic push_seg(input int x0, input int y0, input int x1, input int y1, input int c);
        seg_t s;
        s.x0 = x0; s.y0 = y0; s.x1 = x1; s.y1 = y1; s.c = c;
        seg_q.push_back(s);
        drive_head();
    endtask

    task automatic clear_logs();
        valid_cyc.delete(); qread_cyc.delete(); acc_log.delete();
        busy_cnt = 0; last_busy = -1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || seg_q.size() != 0 || pop_due) && n < budget) begin
            @(negedge clk); n++;
        end
        if (n >= budget) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
        @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
    endtask

    // Queue pop side and ready driver, just after each rising edge.
    always @(posedge clk) begin : drv
        seg_t s;
        #1;
        cyc++;
        if (pop_due) begin
            pop_due = 0;
            if (seg_q.size() == 0) begin
                chk("pop_on_empty", 1, 0);
            end else begin
                s = seg_q.pop_front();
                run_model(s);
                foreach (mdl[i]) if (mdl[i].on) exp_q.push_back(mdl[i]);
            end
            drive_head();
        end
        if (ready_mode == 1)      pixReady = ($urandom_range(0, 3) != 0);
        else if (ready_mode == 0) pixReady = 1'b1;
    end

    // Output compare against the model, mid-cycle.
    always @(negedge clk) begin : cmp
        pix_t a;
        if (!rst_b) begin
            stalled = 0;
        end else begin
            if (busy) begin busy_cnt++; last_busy = cyc; end
            if (stalled) begin
                chk("stall_hold", pk(int'(pixX), int'(pixY), int'(pixColor)) | (int'(pixValid) << 24), st_pack);
                chk("stall_no_qread", int'(qRead), 0);
            end
            if (qRead) begin pop_due = 1; qread_cyc.push_back(cyc); end
            if (pixValid) begin
                valid_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", pk(int'(pixX), int'(pixY), int'(pixColor)), -1);
                end else begin
                    chk("pixel", pk(int'(pixX), int'(pixY), int'(pixColor)),
                        pk(exp_q[0].x, exp_q[0].y, exp_q[0].c));
                    if (pixReady) begin
                        a.x = int'(pixX); a.y = int'(pixY); a.c = int'(pixColor); a.on = 1;
                        acc_log.push_back(a);
                        void'(exp_q.pop_front());
                    end
                end
            end
            stalled = pixValid && !pixReady;
            st_pack = pk(int'(pixX), int'(pixY), int'(pixColor)) | (1 << 24);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, n;
        int hx[4];
        int sy_exp[6];
        int rx[3];
        hx = '{320, 321, 322, 323};
        sy_exp = '{240, 240, 239, 239, 238, 238};
        rx = '{322, 323, 324};

        // Reset state
        #2 rst_b = 1'b0;
        #1;
        chk("rst_pixValid", int'(pixValid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_qRead", int'(qRead), 0);
        chk("rst_pixX", int'(pixX), 0);
        chk("rst_pixY", int'(pixY), 0);
        chk("rst_pixColor", int'(pixColor), 0);
        repeat (3) @(posedge clk);
        #2 rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("idle_busy", int'(busy), 0);

        // Horizontal (0,0)->(3,0) colour 5
        clear_logs(); ready_mode = 0;
        t0 = cyc; push_seg(0, 0, 3, 0, 5);
        wait_idle(200);
        chk("h_qread_count", qread_cyc.size(), 1);
        if (qread_cyc.size() > 0) chk("h_qread_cyc", qread_cyc[0] - t0, 1);
        chk("h_valid_count", valid_cyc.size(), 4);
        for (int i = 0; i < valid_cyc.size() && i < 4; i++) chk("h_valid_cyc", valid_cyc[i] - t0, 3 + i);
        for (int i = 0; i < acc_log.size() && i < 4; i++)
            chk("h_pix", pk(acc_log[i].x, acc_log[i].y, acc_log[i].c), pk(hx[i], 240, 5));
        chk("h_busy_cycles", busy_cnt, 6);

        // Diagonal (0,0)->(-2,2)
        @(posedge clk); #2; clear_logs();
        push_seg(0, 0, -2, 2, 2);
        wait_idle(200);
        chk("d_count", acc_log.size(), 3);
        for (int i = 0; i < acc_log.size() && i < 3; i++)
            chk("d_pix", pk(acc_log[i].x, acc_log[i].y, acc_log[i].c), pk(320 - i, 240 - i, 2));
        if (valid_cyc.size() > 0) chk("d_busy_end", last_busy, valid_cyc[valid_cyc.size()-1]);

        // Shallow (0,0)->(5,2): model pinned against hand values, then DUT
        begin
            seg_t s;
            s.x0 = 0; s.y0 = 0; s.x1 = 5; s.y1 = 2; s.c = 7;
            run_model(s);
            chk("model_shallow_len", mdl.size(), 6);
            for (int i = 0; i < mdl.size() && i < 6; i++) chk("model_shallow_y", mdl[i].y, sy_exp[i]);
        end
        @(posedge clk); #2; clear_logs();
        push_seg(0, 0, 5, 2, 7);
        wait_idle(200);
        chk("s_count", acc_log.size(), 6);
        for (int i = 0; i < acc_log.size() && i < 6; i++)
            chk("s_pix", pk(acc_log[i].x, acc_log[i].y, acc_log[i].c), pk(320 + i, sy_exp[i], 7));

        // Clipping: partially and fully off-screen
        @(posedge clk); #2; clear_logs();
        push_seg(-330, 0, -318, 0, 4);
        wait_idle(300);
        chk("clip_count", acc_log.size(), 3);
        for (int i = 0; i < acc_log.size() && i < 3; i++) chk("clip_col", acc_log[i].x, i);
        chk("clip_busy_cycles", busy_cnt, 15);
        @(posedge clk); #2; clear_logs();
        push_seg(600, 0, 610, 0, 1);
        wait_idle(300);
        chk("off_valid", valid_cyc.size(), 0);
        chk("off_qread", qread_cyc.size(), 1);
        chk("off_busy_cycles", busy_cnt, 13);

        // Backpressure: ready low 5 cycles mid-segment with another segment queued
        @(posedge clk); #2; clear_logs();
        ready_mode = 2; pixReady = 1'b1;
        push_seg(0, 0, 5, 2, 3);
        n = 0;
        while (acc_log.size() < 2 && n < 100) begin @(posedge clk); #2; n++; end
        push_seg(1, 1, 1, 1, 6);
        pixReady = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("bp_qread_during_stall", qread_cyc.size(), 1);
        chk("bp_acc_during_stall", acc_log.size(), 2);
        pixReady = 1'b1;
        wait_idle(300);
        chk("bp_count", acc_log.size(), 7);
        for (int i = 0; i < acc_log.size() && i < 6; i++)
            chk("bp_pix", pk(acc_log[i].x, acc_log[i].y, acc_log[i].c), pk(320 + i, sy_exp[i], 3));
        if (acc_log.size() >= 7) chk("bp_degenerate", pk(acc_log[6].x, acc_log[6].y, acc_log[6].c), pk(321, 239, 6));
        chk("bp_qreads", qread_cyc.size(), 2);
        ready_mode = 0;

        // Async reset mid-DRAW
        @(posedge clk); #2; clear_logs();
        push_seg(0, 0, 20, 0, 1);
        n = 0;
        while (valid_cyc.size() < 2 && n < 100) begin @(posedge clk); #2; n++; end
        rst_b = 1'b0;
        #1;
        chk("mid_rst_pixValid", int'(pixValid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_qRead", int'(qRead), 0);
        exp_q.delete(); pop_due = 0;
        push_seg(2, -3, 4, -3, 6);
        repeat (2) @(posedge clk);
        #2; clear_logs();
        rst_b = 1'b1;
        t0 = cyc;
        wait_idle(200);
        if (qread_cyc.size() > 0) chk("post_rst_qread_cyc", qread_cyc[0] - t0, 1);
        if (valid_cyc.size() > 0) chk("post_rst_first_valid", valid_cyc[0] - t0, 3);
        chk("post_rst_count", acc_log.size(), 3);
        for (int i = 0; i < acc_log.size() && i < 3; i++)
            chk("post_rst_pix", pk(acc_log[i].x, acc_log[i].y, acc_log[i].c), pk(rx[i], 243, 6));

        // Randomized slopes, back-to-back segments, random backpressure
        ready_mode = 1;
        for (int b = 0; b < 10; b++) begin
            @(posedge clk); #2; clear_logs();
            for (int k = 0; k < 4; k++) begin
                int x0, y0, x1, y1;
                x0 = int'($urandom_range(0, 800)) - 400;
                y0 = int'($urandom_range(0, 600)) - 300;
                x1 = x0 + int'($urandom_range(0, 120)) - 60;
                y1 = y0 + int'($urandom_range(0, 120)) - 60;
                push_seg(x0, y0, x1, y1, int'($urandom_range(0, 7)));
            end
            if (b == 9) begin
                push_seg(-1024, 1023, 1023, -1024, 5);
                push_seg(1023, -1024, -1024, -1000, 2);
            end
            wait_idle(20000);
            chk("rand_qreads", qread_cyc.size(), (b == 9) ? 6 : 4);
        end
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
